// File: rtl/approx_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx_eval_pkg
// Purpose  : Shared types and constants for the approximate-adder evaluation
//            sequencer. Holds the FSM state encoding, LFSR constants, default
//            parameter values and the single-step LFSR helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package approx_eval_pkg;

    // Sequencer states, explicitly encoded on two bits
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] c_lfsr_mask  = 32'h8020_0003;

    // An all-zero LFSR state is a lock-up state; this replaces a zero seed
    localparam logic [31:0] c_seed_subst = 32'h0000_0001;

    // Default parameter values for the evaluation controller
    localparam int c_def_w   = 16;
    localparam int c_def_cw  = 20;
    localparam int c_def_sw  = 40;
    localparam int c_def_lat = 1;

    // One Galois LFSR step: shift right, fold the mask back in when the
    // outgoing bit is set
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ c_lfsr_mask) : (s >> 1);
    endfunction

endpackage : approx_eval_pkg
`default_nettype wire

// File: rtl/approx_eval_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : approx_eval_lfsr
// Purpose  : 32-bit Galois LFSR operand generator with seed load and advance.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset (state -> 32'h1)
//            load     - load seed this cycle (zero seed replaced by 32'h1)
//            seed     - seed value
//            advance  - step the LFSR this cycle (ignored while loading)
//            state    - current LFSR state
// Revision : 1.0 - initial release
// ============================================================================
module approx_eval_lfsr
    import approx_eval_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] state
);

    logic [31:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_seed_subst;
        end else if (load) begin
            r_state <= (seed == 32'd0) ? c_seed_subst : seed;
        end else if (advance) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign state = r_state;

endmodule : approx_eval_lfsr
`default_nettype wire

// File: rtl/approx_adder_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : approx_adder_eval_ctrl
// Purpose  : Self-checking evaluation sequencer for one approximate adder.
//            Issues LFSR operand pairs, tracks the exact sum through a
//            LAT-deep pipeline and accumulates error statistics.
// Ports    : clk, rst_n           - clock / asynchronous active-low reset
//            start, abort         - run request / synchronous cancel
//            num_vectors, seed    - run length and LFSR seed (sampled on start)
//            op_a, op_b, op_valid - operands issued to the adder
//            adder_res            - adder result, LAT cycles after issue
//            busy, done           - run status / completion pulse
//            err_count, err_sum,  - erroneous-vector count, saturating sum of
//            err_max                |error| and largest |error|
// Revision : 1.0 - initial release
// ============================================================================
module approx_adder_eval_ctrl
    import approx_eval_pkg::*;
#(
    parameter int W   = c_def_w,
    parameter int CW  = c_def_cw,
    parameter int SW  = c_def_sw,
    parameter int LAT = c_def_lat
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] num_vectors,
    input  logic [31:0]   seed,
    output logic [W-1:0]  op_a,
    output logic [W-1:0]  op_b,
    output logic          op_valid,
    input  logic [W:0]    adder_res,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] err_count,
    output logic [SW-1:0] err_sum,
    output logic [W:0]    err_max
);

    // Accumulator width wide enough that sum + diff cannot overflow before
    // the saturation test
    localparam int              c_aw       = ((SW > W + 2) ? SW : W + 2) + 1;
    localparam logic [CW-1:0]   c_cnt_one  = CW'(1);
    localparam logic [W+1:0]    c_diff_one = (W + 2)'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_num;
    logic [CW-1:0] r_issue_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic [W-1:0]  r_op_a_hold;
    logic [W-1:0]  r_op_b_hold;
    logic [31:0]   w_lfsr;
    logic          w_accept;
    logic          w_issue;
    logic          w_last_issue;
    logic          w_flush;
    logic [W:0]    w_exact;
    logic          w_tail_valid;
    logic [W:0]    w_tail_exact;
    logic          w_pipe_pending;
    logic [W+1:0]  w_diff_raw;
    logic [W+1:0]  w_diff;
    logic [c_aw-1:0] w_sum_ext;
    logic [SW-1:0] w_sum_sat;
    logic [CW-1:0] r_err_count;
    logic [SW-1:0] r_err_sum;
    logic [W:0]    r_err_max;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_accept     = (r_state == IDLE) && start && !abort;
    assign w_issue      = (r_state == RUN);
    assign w_cnt_inc    = r_issue_cnt + c_cnt_one;
    assign w_last_issue = w_issue && (w_cnt_inc == r_num);
    assign w_flush      = abort && ((r_state == RUN) || (r_state == DRAIN));

    // ------------------------------------------------------------------
    // Operand generator
    // ------------------------------------------------------------------
    approx_eval_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_accept),
        .seed    (seed),
        .advance (w_issue),
        .state   (w_lfsr)
    );

    // Operands follow the LFSR during RUN and freeze on the last issued pair
    // afterwards, so the adder input does not toggle between runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a_hold <= '0;
            r_op_b_hold <= '0;
        end else if (w_issue) begin
            r_op_a_hold <= w_lfsr[W-1:0];
            r_op_b_hold <= w_lfsr[31:32-W];
        end
    end

    assign op_a     = w_issue ? w_lfsr[W-1:0]   : r_op_a_hold;
    assign op_b     = w_issue ? w_lfsr[31:32-W] : r_op_b_hold;
    assign op_valid = w_issue;
    assign w_exact  = {1'b0, op_a} + {1'b0, op_b};

    // ------------------------------------------------------------------
    // Issue counter and run length
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num       <= '0;
            r_issue_cnt <= '0;
        end else if (w_accept) begin
            r_num       <= num_vectors;
            r_issue_cnt <= '0;
        end else if (w_issue) begin
            r_issue_cnt <= w_cnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // Exact-sum pipeline matching the adder latency
    // ------------------------------------------------------------------
    generate
        if (LAT == 0) begin : g_lat_zero
            assign w_tail_valid   = w_issue;
            assign w_tail_exact   = w_exact;
            assign w_pipe_pending = 1'b0;
        end else begin : g_lat_pipe
            logic [LAT-1:0] r_pv;
            logic [W:0]     r_pe [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pv <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        r_pe[i] <= '0;
                    end
                end else begin
                    r_pv[0] <= w_issue && !w_flush;
                    r_pe[0] <= w_exact;
                    for (int i = 1; i < LAT; i++) begin
                        r_pv[i] <= r_pv[i-1] && !w_flush;
                        r_pe[i] <= r_pe[i-1];
                    end
                end
            end

            assign w_tail_valid = r_pv[LAT-1];
            assign w_tail_exact = r_pe[LAT-1];

            // Pending means something other than the entry currently being
            // compared is still in flight; the tail's update registers on the
            // same edge that would move the FSM to DONE
            if (LAT == 1) begin : g_pend_single
                assign w_pipe_pending = 1'b0;
            end else begin : g_pend_multi
                assign w_pipe_pending = |r_pv[LAT-2:0];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Error measurement
    // ------------------------------------------------------------------
    // The signed difference of two W+1 bit values fits in W+2 bits and its
    // magnitude fits in W+1 bits
    assign w_diff_raw = {1'b0, adder_res} - {1'b0, w_tail_exact};
    assign w_diff     = w_diff_raw[W+1] ? (~w_diff_raw + c_diff_one) : w_diff_raw;
    assign w_sum_ext  = c_aw'(r_err_sum) + c_aw'(w_diff);
    assign w_sum_sat  = (|w_sum_ext[c_aw-1:SW]) ? {SW{1'b1}} : w_sum_ext[SW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
            r_err_sum   <= '0;
            r_err_max   <= '0;
        end else if (w_accept) begin
            r_err_count <= '0;
            r_err_sum   <= '0;
            r_err_max   <= '0;
        end else if (w_tail_valid) begin
            if (w_diff != '0) begin
                r_err_count <= w_cnt_inc_err(r_err_count);
            end
            r_err_sum <= w_sum_sat;
            if (w_diff[W:0] > r_err_max) begin
                r_err_max <= w_diff[W:0];
            end
        end
    end

    // Count never exceeds num_vectors, so a plain increment cannot wrap
    function automatic logic [CW-1:0] w_cnt_inc_err(input logic [CW-1:0] v);
        w_cnt_inc_err = v + c_cnt_one;
    endfunction

    assign err_count = r_err_count;
    assign err_sum   = r_err_sum;
    assign err_max   = r_err_max;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (num_vectors == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last_issue) begin
                    // With a combinational adder the last compare happens in
                    // the last issue cycle, so there is nothing to drain
                    w_state_nxt = (LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (!w_pipe_pending) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (r_state == RUN) || (r_state == DRAIN);
    assign done = (r_state == DONE);

endmodule : approx_adder_eval_ctrl
`default_nettype wire

// File: tb/tb_approx_adder_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_adder_eval_ctrl
// Purpose  : Directed self-checking bench. dut  : LAT=1, SW=8 with a
//            registered adder stub selectable by 'mode' (exact / bit0 forced
//            to 0 / constant 0). dut0 : LAT=0, SW=40 with an exact
//            combinational adder, sharing the control inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_adder_eval_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [19:0] num_vectors = '0;
    logic [31:0] seed = '0;
    int          mode = 0;

    logic [15:0] op_a, op_b;
    logic        op_valid, busy, done;
    logic [16:0] adder_res = '0;
    logic [19:0] err_count;
    logic [7:0]  err_sum;
    logic [16:0] err_max;

    logic [15:0] op_a_0, op_b_0;
    logic        op_valid_0, busy_0, done_0;
    logic [16:0] adder_res_0;
    logic [19:0] err_count_0;
    logic [39:0] err_sum_0;
    logic [16:0] err_max_0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // One-cycle-latency adder stub
    always @(posedge clk) begin
        case (mode)
            1:       adder_res <= ({1'b0, op_a} + {1'b0, op_b}) & 17'h1FFFE;
            2:       adder_res <= 17'd0;
            default: adder_res <= {1'b0, op_a} + {1'b0, op_b};
        endcase
    end

    assign adder_res_0 = {1'b0, op_a_0} + {1'b0, op_b_0};

    approx_adder_eval_ctrl #(.W(16), .CW(20), .SW(8), .LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_vectors(num_vectors), .seed(seed),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .adder_res(adder_res),
        .busy(busy), .done(done),
        .err_count(err_count), .err_sum(err_sum), .err_max(err_max)
    );

    approx_adder_eval_ctrl #(.W(16), .CW(20), .SW(40), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_vectors(num_vectors), .seed(seed),
        .op_a(op_a_0), .op_b(op_b_0), .op_valid(op_valid_0), .adder_res(adder_res_0),
        .busy(busy_0), .done(done_0),
        .err_count(err_count_0), .err_sum(err_sum_0), .err_max(err_max_0)
    );

    // Reference Galois LFSR, mask 32'h8020_0003
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Reference statistics for the stub in 'md' with an 8-bit saturating sum
    task automatic model(input int md, input int n, input logic [31:0] sd,
                         output int cnt, output int sum, output int mx);
        logic [31:0] s;
        int ex, r, d;
        s = (sd == 32'd0) ? 32'd1 : sd;
        cnt = 0; sum = 0; mx = 0;
        for (int i = 0; i < n; i++) begin
            ex = int'(s[15:0]) + int'(s[31:16]);
            r  = (md == 1) ? (ex & ~1) : (md == 2) ? 0 : ex;
            d  = (r > ex) ? (r - ex) : (ex - r);
            if (d != 0) cnt++;
            sum = sum + d;
            if (sum > 255) sum = 255;
            if (d > mx) mx = d;
            s = lfsr_next(s);
        end
    endtask

    // Start a run and follow it until both DUTs pulse done or the budget
    // expires (d1/d0 stay -1). Optionally re-pulse start at cycle restart_at.
    task automatic do_run(input logic [19:0] n, input logic [31:0] sd, input int budget,
                          input int restart_at, output int d1, output int d0,
                          output int nval, output int seqbad);
        logic [31:0] s;
        num_vectors = n;
        seed        = sd;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        s = (sd == 32'd0) ? 32'd1 : sd;
        d1 = -1; d0 = -1; nval = 0; seqbad = 0;
        for (int c = 1; c <= budget; c++) begin
            if (c == restart_at) begin
                start = 1'b1; num_vectors = 20'd3; seed = 32'h99;
            end else begin
                start = 1'b0;
            end
            if (op_valid === 1'b1) begin
                nval++;
                if (op_a !== s[15:0] || op_b !== s[31:16]) seqbad++;
                s = lfsr_next(s);
            end
            if (done === 1'b1 && d1 < 0) d1 = c;
            if (done_0 === 1'b1 && d0 < 0) d0 = c;
            if (d1 >= 0 && d0 >= 0) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done got=%0b exp=0", done); end
        total++; if (op_valid !== 1'b0)  begin bad++; $display("FAIL rst_op_valid got=%0b exp=0", op_valid); end
        total++; if (op_a !== 16'd0)     begin bad++; $display("FAIL rst_op_a got=%h exp=0", op_a); end
        total++; if (op_b !== 16'd0)     begin bad++; $display("FAIL rst_op_b got=%h exp=0", op_b); end
        total++; if (err_count !== 20'd0) begin bad++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
        total++; if (err_sum !== 8'd0)   begin bad++; $display("FAIL rst_err_sum got=%0d exp=0", err_sum); end
        total++; if (err_max !== 17'd0)  begin bad++; $display("FAIL rst_err_max got=%0d exp=0", err_max); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exact();
        int d1, d0, nv, sb;
        mode = 0;
        do_run(20'd1000, 32'h1, 1100, 0, d1, d0, nv, sb);
        total++; if (d0 !== 1001) begin bad++; $display("FAIL exact_done_lat0 got=%0d exp=1001", d0); end
        total++; if (d1 !== 1002) begin bad++; $display("FAIL exact_done_lat1 got=%0d exp=1002", d1); end
        total++; if (nv !== 1000) begin bad++; $display("FAIL exact_issues got=%0d exp=1000", nv); end
        total++; if (sb !== 0)    begin bad++; $display("FAIL exact_op_seq got=%0d bad pairs exp=0", sb); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL exact_busy_at_done got=%0b exp=0", busy); end
        total++; if (err_count_0 !== 20'd0 || err_sum_0 !== 40'd0 || err_max_0 !== 17'd0) begin
            bad++; $display("FAIL exact_stats_lat0 got=%0d/%0d/%0d exp=0/0/0", err_count_0, err_sum_0, err_max_0);
        end
        total++; if (err_count !== 20'd0 || err_sum !== 8'd0 || err_max !== 17'd0) begin
            bad++; $display("FAIL exact_stats_lat1 got=%0d/%0d/%0d exp=0/0/0", err_count, err_sum, err_max);
        end
    endtask

    task automatic test_odd();
        int d1, d0, nv, sb, ec, es, em;
        mode = 1;
        model(1, 8, 32'h1234_5678, ec, es, em);
        do_run(20'd8, 32'h1234_5678, 40, 0, d1, d0, nv, sb);
        total++; if (d1 !== 10) begin bad++; $display("FAIL odd_done got=%0d exp=10", d1); end
        total++; if (nv !== 8 || sb !== 0) begin bad++; $display("FAIL odd_issue got=%0d/%0d exp=8/0", nv, sb); end
        total++; if (err_count !== 20'(ec)) begin bad++; $display("FAIL odd_err_count got=%0d exp=%0d", err_count, ec); end
        total++; if (err_sum !== 8'(es))    begin bad++; $display("FAIL odd_err_sum got=%0d exp=%0d", err_sum, es); end
        total++; if (err_max !== 17'(em))   begin bad++; $display("FAIL odd_err_max got=%0d exp=%0d", err_max, em); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL odd_done_one_cycle got=%0b exp=0", done); end
        total++; if (err_count !== 20'(ec)) begin bad++; $display("FAIL odd_stats_hold got=%0d exp=%0d", err_count, ec); end
    endtask

    task automatic test_sat();
        int d1, d0, nv, sb, ec, es, em;
        mode = 2;
        model(2, 4, 32'hDEAD_BEEF, ec, es, em);
        do_run(20'd4, 32'hDEAD_BEEF, 30, 0, d1, d0, nv, sb);
        total++; if (d1 !== 6) begin bad++; $display("FAIL sat_done got=%0d exp=6", d1); end
        total++; if (err_sum !== 8'hFF || es != 255) begin bad++; $display("FAIL sat_err_sum got=%0d exp=255 model=%0d", err_sum, es); end
        total++; if (err_max !== 17'(em))   begin bad++; $display("FAIL sat_err_max got=%0d exp=%0d", err_max, em); end
        total++; if (err_count !== 20'(ec)) begin bad++; $display("FAIL sat_err_count got=%0d exp=%0d", err_count, ec); end
    endtask

    task automatic test_zero();
        int d1, d0, nv, sb;
        mode = 1;
        do_run(20'd0, 32'h5, 10, 0, d1, d0, nv, sb);
        total++; if (d1 !== 1 || d0 !== 1) begin bad++; $display("FAIL zero_done got=%0d/%0d exp=1/1", d1, d0); end
        total++; if (nv !== 0) begin bad++; $display("FAIL zero_op_valid got=%0d issues exp=0", nv); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%0b exp=0", busy); end
        total++; if (err_count !== 20'd0 || err_sum !== 8'd0 || err_max !== 17'd0) begin
            bad++; $display("FAIL zero_stats got=%0d/%0d/%0d exp=0/0/0", err_count, err_sum, err_max);
        end
    endtask

    task automatic test_abort();
        int d1, d0, nv, sb, ec, es, em, stray;
        mode = 1;
        num_vectors = 20'd100; seed = 32'hCAFE_F00D;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL abort_issue5 got=%0b exp=1", op_valid); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (busy !== 1'b0 || busy_0 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b/%0b exp=0/0", busy, busy_0); end
        stray = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1 || op_valid === 1'b1 || busy === 1'b1) stray++;
            @(negedge clk);
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL abort_quiet got=%0d active cycles exp=0", stray); end
        model(1, 8, 32'h0BAD_F00D, ec, es, em);
        do_run(20'd8, 32'h0BAD_F00D, 40, 0, d1, d0, nv, sb);
        total++; if (d1 !== 10) begin bad++; $display("FAIL abort_rerun_done got=%0d exp=10", d1); end
        total++; if (err_count !== 20'(ec) || err_sum !== 8'(es) || err_max !== 17'(em)) begin
            bad++; $display("FAIL abort_rerun_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", err_count, err_sum, err_max, ec, es, em);
        end
    endtask

    task automatic test_busy_start();
        int d1, d0, nv, sb, ec, es, em;
        mode = 1;
        model(1, 20, 32'h1357_9BDF, ec, es, em);
        do_run(20'd20, 32'h1357_9BDF, 60, 5, d1, d0, nv, sb);
        total++; if (d1 !== 22 || d0 !== 21) begin bad++; $display("FAIL restart_done got=%0d/%0d exp=22/21", d1, d0); end
        total++; if (nv !== 20 || sb !== 0) begin bad++; $display("FAIL restart_issue got=%0d/%0d exp=20/0", nv, sb); end
        total++; if (err_count !== 20'(ec) || err_sum !== 8'(es) || err_max !== 17'(em)) begin
            bad++; $display("FAIL restart_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", err_count, err_sum, err_max, ec, es, em);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        mode = 1;
        num_vectors = 20'd50; seed = 32'h2468_ACE0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || op_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_ctrl got=%0b%0b%0b exp=000", busy, done, op_valid);
        end
        total++; if (op_a !== 16'd0 || op_b !== 16'd0) begin bad++; $display("FAIL midrst_ops got=%h/%h exp=0/0", op_a, op_b); end
        total++; if (err_count !== 20'd0 || err_sum !== 8'd0 || err_max !== 17'd0) begin
            bad++; $display("FAIL midrst_stats got=%0d/%0d/%0d exp=0/0/0", err_count, err_sum, err_max);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (done === 1'b1 || done_0 === 1'b1 || op_valid === 1'b1) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL midrst_quiet got=%0d active cycles exp=0", stray); end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_odd();
        test_sat();
        test_zero();
        test_abort();
        test_busy_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_approx_adder_eval_ctrl
`default_nettype wire

// File: doc/approx_adder_eval_ctrl.md
Name: approx_adder_eval_ctrl

Overview:
Self-checking evaluation sequencer for one approximate adder instance (ACA-I/II, ETA-II, GeAr, GDA, LOA or RCA, all N=16).
- Generates pseudo-random operand pairs with an internal LFSR and issues one pair per cycle to the adder.
- Compares each adder result against the exact sum and accumulates error statistics.
- Sits between a host or test harness (start/done handshake) and the adder under evaluation, so error characterisation runs on silicon or FPGA instead of in a file-based bench.

Parameters:
W, 16, operand width; legal range 1..16, since both operands are taken from one 32-bit LFSR.
CW, 20, width of the vector-count input and the internal issue counter.
SW, 40, width of the error-sum accumulator.
LAT, 1, adder result latency in cycles (0 = purely combinational adder); legal range 0..4.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a run; honoured only in IDLE.
abort  in  1  synchronous run cancel.
num_vectors  in  CW  number of operand pairs per run, sampled on accepted start.
seed  in  32  LFSR seed, sampled on accepted start; value 0 is replaced by 32'h1.
op_a  out  W  operand A to the adder.
op_b  out  W  operand B to the adder.
op_valid  out  1  high in each issue cycle.
adder_res  in  W+1  adder result, LAT cycles after issue.
busy  out  1  high from the cycle after an accepted start until done or abort.
done  out  1  one-cycle pulse when final statistics are visible.
err_count  out  CW  count of vectors with a result different from the exact sum.
err_sum  out  SW  saturating sum of |res - exact|.
err_max  out  W+1  largest |res - exact| seen in the run.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, LFSR = 32'h1, pipeline valids cleared. Reset applies at any time; it kills any run in progress and produces no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN on start && !abort. That edge latches num_vectors, latches the LFSR seed (0 replaced by 1), and clears err_count, err_sum and err_max.
- If num_vectors == 0: IDLE goes directly to DONE, the statistics stay 0, and done pulses on the next cycle.
- RUN: op_valid = 1 every cycle.
  - op_a = lfsr[W-1:0], op_b = lfsr[31:32-W].
  - The LFSR advances after each issue. It is a 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1 (mask 32'h8020_0003).
  - Exactly num_vectors issues occur, then RUN goes to DRAIN.
  - op_a and op_b hold their last values outside RUN.
- Pipeline: a LAT-deep shift register carries {valid, exact = op_a+op_b (W+1 bits, zero-extended)} alongside the adder.
  - At each cycle where the pipeline-tail valid is set, adder_res is compared with the tail exact value.
  - LAT = 0 means adder_res is compared in the issue cycle.
- Statistic updates are registered and visible one cycle after the compare:
  - diff = |adder_res - exact|, computed at W+2 bits.
  - If diff != 0, err_count increments.
  - err_sum += diff, saturating at all-ones.
  - err_max = max(err_max, diff).
- DRAIN: wait until the pipeline is empty and the last update is registered, then go to DONE.
- DONE: done = 1 for exactly one cycle, busy = 0 in that cycle, next state IDLE. The statistics hold until the next accepted start.
- Timing for N > 0, with start accepted at cycle 0:
  - issues occur on cycles 1..N;
  - the last compare is on cycle N+LAT;
  - done pulses on cycle N+LAT+1.
- start while busy is ignored; the in-flight run is unaffected.
- abort in RUN or DRAIN: next state IDLE, busy drops, no done pulse, pipeline valids cleared. The statistics keep their partial values.
- abort in IDLE or DONE has no effect. Simultaneous start and abort in IDLE: abort wins and the run does not start.
- err_count cannot wrap, because it never exceeds num_vectors < 2^CW.

Decomposition:
- Package approx_eval_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - the LFSR tap mask constant 32'h8020_0003;
  - the nonzero-seed substitute 32'h1;
  - the W, CW, SW and LAT defaults.
- One sub-module, approx_eval_lfsr: 32-bit Galois LFSR with load, seed and advance inputs. The FSM, pipeline and accumulators stay in the top module.

Test Plan:
- Exact adder (res = in1+in2), LAT=0, seed 32'h1, num_vectors 1000 -> err_count 0, err_sum 0, err_max 0, done on cycle 1001.
- Adder stub that forces res[0]=0, LAT=1, num_vectors 8 -> err_count equals the number of odd exact sums (checked against a reference LFSR model), err_max 1, done on cycle 10.
- Adder stub returning 0, W=16, SW=8, num_vectors 4 -> err_sum saturates at 8'hFF and does not wrap; err_max equals the largest exact sum.
- num_vectors 0 -> op_valid never asserted, done pulses the cycle after start, statistics 0.
- abort pulsed at issue 5 of a 100-vector run -> busy low next cycle, no done pulse, no further op_valid; a subsequent start clears the statistics and runs to completion.
- start re-pulsed mid-run, and rst_n asserted mid-run -> start has no effect; reset forces all outputs to 0 asynchronously and gives no done pulse.
